// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-side signals around mem_port_arbiter.
// slave: the arbiter's view; master: the surrounding core/memory environment's view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned MTYPE_W = 3
);
    // fetch requester
    logic               f_req;
    logic [ADDR_W-1:0]  f_addr;
    logic               f_gnt;
    logic               f_rvalid;
    logic [INSTR_W-1:0] f_rdata;

    // data requester
    logic               d_req;
    logic               d_we;
    logic [MTYPE_W-1:0] d_type;
    logic [ADDR_W-1:0]  d_addr;
    logic [DATA_W-1:0]  d_wdata;
    logic               d_gnt;
    logic               d_rvalid;
    logic [DATA_W-1:0]  d_rdata;

    // memory bus
    logic               mem_req;
    logic               mem_we;
    logic [MTYPE_W-1:0] mem_type;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic               mem_ready;
    logic               mem_rvalid;
    logic [DATA_W-1:0]  mem_rdata;

    logic               busy;

    modport slave (
        input  f_req, f_addr,
        input  d_req, d_we, d_type, d_addr, d_wdata,
        input  mem_ready, mem_rvalid, mem_rdata,
        output f_gnt, f_rvalid, f_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        output busy
    );

    modport master (
        output f_req, f_addr,
        output d_req, d_we, d_type, d_addr, d_wdata,
        output mem_ready, mem_rvalid, mem_rdata,
        input  f_gnt, f_rvalid, f_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_req, mem_we, mem_type, mem_addr, mem_wdata,
        input  busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory port between fetch and data requesters, one transaction at a time.
// Define MEM_ARB_STARVE_GUARD_EN to force a fetch win after STARVE_MAX consecutive fetch losses.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned INSTR_W = 32,
    parameter int unsigned MTYPE_W = 3
`ifdef MEM_ARB_STARVE_GUARD_EN
   ,parameter int unsigned STARVE_MAX = 4
`endif
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);

    localparam logic [MTYPE_W-1:0] FETCH_TYPE = MTYPE_W'(3'b010);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arbStateT;

    arbStateT state;
    arbStateT stateNext;

    // registered outputs and captured transaction
    logic               ownerData;
    logic               memReq;
    logic               memWe;
    logic [MTYPE_W-1:0] memType;
    logic [ADDR_W-1:0]  memAddr;
    logic [DATA_W-1:0]  memWdata;
    logic               fRvalid;
    logic [INSTR_W-1:0] fRdata;
    logic               dRvalid;
    logic [DATA_W-1:0]  dRdata;
    logic               busyQ;

    // per-cycle decisions from the output process
    logic grantF;
    logic grantD;
    logic memAccept;
    logic respDone;
    logic forceFetch;

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] starveCnt;

    // counts data grants that left a fetch waiting; saturates, cleared by a fetch grant
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveCnt <= '0;
        end else if (grantF) begin
            starveCnt <= '0;
        end else if (grantD && bus.f_req && (starveCnt != CNT_MAX)) begin
            starveCnt <= starveCnt + CNT_W'(1);
        end
    end

    assign forceFetch = bus.f_req && (starveCnt == CNT_MAX);
`else
    assign forceFetch = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE: begin
                if (grantF || grantD) begin
                    stateNext = REQ;
                end
            end
            REQ: begin
                if (memAccept) begin
                    stateNext = memWe ? IDLE : RESP;
                end
            end
            RESP: begin
                if (respDone) begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // output/decision logic; grants are held off while reset is asserted
    always_comb begin
        grantF    = 1'b0;
        grantD    = 1'b0;
        memAccept = 1'b0;
        respDone  = 1'b0;
        case (state)
            IDLE: begin
                if (reset) begin
                    grantF = bus.f_req && (!bus.d_req || forceFetch);
                    grantD = bus.d_req && !grantF;
                end
            end
            REQ: begin
                memAccept = memReq && bus.mem_ready;
            end
            RESP: begin
                respDone = bus.mem_rvalid;
            end
            default: begin
                grantF = 1'b0;
            end
        endcase
    end

    // transaction capture, memory request and response registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ownerData <= 1'b0;
            memReq    <= 1'b0;
            memWe     <= 1'b0;
            memType   <= '0;
            memAddr   <= '0;
            memWdata  <= '0;
            fRvalid   <= 1'b0;
            fRdata    <= '0;
            dRvalid   <= 1'b0;
            dRdata    <= '0;
            busyQ     <= 1'b0;
        end else begin
            fRvalid <= 1'b0;
            dRvalid <= 1'b0;
            busyQ   <= (stateNext != IDLE);

            if (grantF || grantD) begin
                ownerData <= grantD;
                memReq    <= 1'b1;
                memWe     <= grantD && bus.d_we;
                memType   <= grantD ? bus.d_type  : FETCH_TYPE;
                memAddr   <= grantD ? bus.d_addr  : bus.f_addr;
                memWdata  <= grantD ? bus.d_wdata : '0;
            end

            // a store completes on acceptance, with zero load data
            if (memAccept) begin
                memReq <= 1'b0;
                if (memWe) begin
                    dRvalid <= 1'b1;
                    dRdata  <= '0;
                end
            end

            if (respDone) begin
                if (ownerData) begin
                    dRvalid <= 1'b1;
                    dRdata  <= bus.mem_rdata;
                end else begin
                    fRvalid <= 1'b1;
                    fRdata  <= bus.mem_rdata[INSTR_W-1:0];
                end
            end
        end
    end

    assign bus.f_gnt     = grantF;
    assign bus.d_gnt     = grantD;
    assign bus.f_rvalid  = fRvalid;
    assign bus.f_rdata   = fRdata;
    assign bus.d_rvalid  = dRvalid;
    assign bus.d_rdata   = dRdata;
    assign bus.mem_req   = memReq;
    assign bus.mem_we    = memWe;
    assign bus.mem_type  = memType;
    assign bus.mem_addr  = memAddr;
    assign bus.mem_wdata = memWdata;
    assign bus.busy      = busyQ;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
module tb_mem_port_arbiter;

    logic clk;
    logic reset;
    int   nCmp;
    int   nErr;

    mem_port_arbiter_if bus ();

    mem_port_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.f_req      = 1'b0;
        bus.f_addr     = '0;
        bus.d_req      = 1'b0;
        bus.d_we       = 1'b0;
        bus.d_type     = '0;
        bus.d_addr     = '0;
        bus.d_wdata    = '0;
        bus.mem_ready  = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        reset = 1'b0;
        step();
        bus.f_req = 1'b1;
        bus.f_addr = 64'h10;
        step();
        #1;
        nCmp++; if (bus.f_gnt !== 1'b0) begin nErr++; $display("FAIL rst_f_gnt: got %b want 0", bus.f_gnt); end
        nCmp++; if (bus.mem_req !== 1'b0) begin nErr++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        nCmp++; if (bus.busy !== 1'b0) begin nErr++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
        nCmp++; if ({bus.f_rvalid, bus.d_rvalid} !== 2'b00) begin nErr++; $display("FAIL rst_rvalid: got %b want 00", {bus.f_rvalid, bus.d_rvalid}); end
        nCmp++; if (bus.mem_addr !== 64'h0) begin nErr++; $display("FAIL rst_mem_addr: got %h want 0", bus.mem_addr); end
        bus.f_req = 1'b0;
        reset = 1'b1;
        step();
        step();
    endtask

    task automatic test_single_fetch();
        bus.f_req = 1'b1; bus.f_addr = 64'h1000; bus.mem_ready = 1'b1;
        #1;
        nCmp++; if ({bus.f_gnt, bus.d_gnt} !== 2'b10) begin nErr++; $display("FAIL sf_gnt: got %b want 10", {bus.f_gnt, bus.d_gnt}); end
        step(); // cycle 1
        bus.f_req = 1'b0;
        nCmp++; if (bus.mem_req !== 1'b1) begin nErr++; $display("FAIL sf_mem_req: got %b want 1", bus.mem_req); end
        nCmp++; if (bus.mem_addr !== 64'h1000) begin nErr++; $display("FAIL sf_mem_addr: got %h want 1000", bus.mem_addr); end
        nCmp++; if ({bus.mem_we, bus.mem_type} !== 4'b0010) begin nErr++; $display("FAIL sf_we_type: got %b want 0010", {bus.mem_we, bus.mem_type}); end
        step(); // cycle 2
        nCmp++; if (bus.mem_req !== 1'b0) begin nErr++; $display("FAIL sf_mem_req_drop: got %b want 0", bus.mem_req); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h13;
        step(); // cycle 3
        bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0;
        nCmp++; if (bus.f_rvalid !== 1'b1) begin nErr++; $display("FAIL sf_f_rvalid: got %b want 1", bus.f_rvalid); end
        nCmp++; if (bus.f_rdata !== 32'h13) begin nErr++; $display("FAIL sf_f_rdata: got %h want 00000013", bus.f_rdata); end
        nCmp++; if (bus.busy !== 1'b0) begin nErr++; $display("FAIL sf_busy: got %b want 0", bus.busy); end
        nCmp++; if (bus.d_rvalid !== 1'b0) begin nErr++; $display("FAIL sf_d_rvalid: got %b want 0", bus.d_rvalid); end
        step();
        nCmp++; if (bus.f_rvalid !== 1'b0) begin nErr++; $display("FAIL sf_pulse_len: got %b want 0", bus.f_rvalid); end
    endtask

    task automatic test_priority();
        bus.f_req = 1'b1; bus.f_addr = 64'h1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_type = 3'b011; bus.d_addr = 64'h2000;
        bus.mem_ready = 1'b1;
        #1;
        nCmp++; if ({bus.f_gnt, bus.d_gnt} !== 2'b01) begin nErr++; $display("FAIL pr_gnt: got %b want 01", {bus.f_gnt, bus.d_gnt}); end
        step(); // cycle 1
        bus.d_req = 1'b0;
        nCmp++; if (bus.mem_addr !== 64'h2000) begin nErr++; $display("FAIL pr_mem_addr_d: got %h want 2000", bus.mem_addr); end
        nCmp++; if (bus.mem_type !== 3'b011) begin nErr++; $display("FAIL pr_mem_type_d: got %b want 011", bus.mem_type); end
        #1;
        nCmp++; if (bus.f_gnt !== 1'b0) begin nErr++; $display("FAIL pr_no_gnt_req: got %b want 0", bus.f_gnt); end
        step(); // cycle 2
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hA5A5_0000_1234_5678;
        #1;
        nCmp++; if (bus.f_gnt !== 1'b0) begin nErr++; $display("FAIL pr_no_gnt_resp: got %b want 0", bus.f_gnt); end
        step(); // cycle 3
        bus.mem_rvalid = 1'b0;
        nCmp++; if (bus.d_rvalid !== 1'b1) begin nErr++; $display("FAIL pr_d_rvalid: got %b want 1", bus.d_rvalid); end
        nCmp++; if (bus.d_rdata !== 64'hA5A5_0000_1234_5678) begin nErr++; $display("FAIL pr_d_rdata: got %h want a5a5000012345678", bus.d_rdata); end
        #1;
        nCmp++; if ({bus.f_gnt, bus.d_gnt} !== 2'b10) begin nErr++; $display("FAIL pr_f_gnt_after: got %b want 10", {bus.f_gnt, bus.d_gnt}); end
        step(); // cycle 4
        bus.f_req = 1'b0;
        nCmp++; if (bus.mem_addr !== 64'h1000) begin nErr++; $display("FAIL pr_mem_addr_f: got %h want 1000", bus.mem_addr); end
        nCmp++; if (bus.mem_type !== 3'b010) begin nErr++; $display("FAIL pr_mem_type_f: got %b want 010", bus.mem_type); end
        step(); // cycle 5
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hCAFE_BABE_0000_0093;
        step(); // cycle 6
        bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b0;
        nCmp++; if (bus.f_rvalid !== 1'b1) begin nErr++; $display("FAIL pr_f_rvalid: got %b want 1", bus.f_rvalid); end
        nCmp++; if (bus.f_rdata !== 32'h0000_0093) begin nErr++; $display("FAIL pr_f_rdata: got %h want 00000093", bus.f_rdata); end
        step();
    endtask

    task automatic test_spurious_rvalid();
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_type = 3'b011; bus.d_addr = 64'h4000;
        bus.mem_ready = 1'b0;
        #1;
        nCmp++; if (bus.d_gnt !== 1'b1) begin nErr++; $display("FAIL sp_d_gnt: got %b want 1", bus.d_gnt); end
        step(); // cycle 1: REQ, memory not ready, stray rvalid
        bus.d_req = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'hBAD;
        step(); // cycle 2
        bus.mem_rvalid = 1'b0; bus.mem_ready = 1'b1;
        nCmp++; if ({bus.f_rvalid, bus.d_rvalid} !== 2'b00) begin nErr++; $display("FAIL sp_no_strobe: got %b want 00", {bus.f_rvalid, bus.d_rvalid}); end
        nCmp++; if (bus.mem_req !== 1'b1) begin nErr++; $display("FAIL sp_mem_req_held: got %b want 1", bus.mem_req); end
        step(); // cycle 3: RESP
        bus.mem_ready = 1'b0;
        nCmp++; if (bus.d_rvalid !== 1'b0) begin nErr++; $display("FAIL sp_no_strobe2: got %b want 0", bus.d_rvalid); end
        nCmp++; if (bus.busy !== 1'b1) begin nErr++; $display("FAIL sp_busy: got %b want 1", bus.busy); end
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h1122_3344_5566_7788;
        step(); // cycle 4
        bus.mem_rvalid = 1'b0;
        nCmp++; if (bus.d_rvalid !== 1'b1) begin nErr++; $display("FAIL sp_d_rvalid: got %b want 1", bus.d_rvalid); end
        nCmp++; if (bus.d_rdata !== 64'h1122_3344_5566_7788) begin nErr++; $display("FAIL sp_d_rdata: got %h want 1122334455667788", bus.d_rdata); end
        step();
    endtask

    task automatic test_store_wait();
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_type = 3'b011;
        bus.d_addr = 64'h3008; bus.d_wdata = 64'hDEAD_BEEF;
        bus.mem_ready = 1'b0;
        #1;
        nCmp++; if (bus.d_gnt !== 1'b1) begin nErr++; $display("FAIL st_d_gnt: got %b want 1", bus.d_gnt); end
        step();
        bus.d_req = 1'b0; bus.d_wdata = '0; bus.d_addr = '0;
        for (int i = 0; i < 3; i++) begin
            nCmp++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, 1'b1, 64'h3008, 64'hDEAD_BEEF}) begin
                nErr++;
                $display("FAIL st_hold%0d: got req=%b we=%b addr=%h wdata=%h want 1 1 3008 deadbeef", i, bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata);
            end
            step();
        end
        bus.mem_ready = 1'b1;
        nCmp++; if (bus.mem_req !== 1'b1) begin nErr++; $display("FAIL st_req4: got %b want 1", bus.mem_req); end
        step();
        bus.mem_ready = 1'b0;
        nCmp++; if (bus.d_rvalid !== 1'b1) begin nErr++; $display("FAIL st_d_rvalid: got %b want 1", bus.d_rvalid); end
        nCmp++; if (bus.d_rdata !== 64'h0) begin nErr++; $display("FAIL st_d_rdata: got %h want 0", bus.d_rdata); end
        nCmp++; if ({bus.mem_req, bus.busy} !== 2'b00) begin nErr++; $display("FAIL st_idle: got %b want 00", {bus.mem_req, bus.busy}); end
        step();
        nCmp++; if (bus.d_rvalid !== 1'b0) begin nErr++; $display("FAIL st_pulse_len: got %b want 0", bus.d_rvalid); end
    endtask

    task automatic test_reset_in_resp();
        bus.f_req = 1'b1; bus.f_addr = 64'h5000; bus.mem_ready = 1'b1;
        step();
        bus.f_req = 1'b0;
        step(); // now waiting for the response
        bus.mem_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        nCmp++; if ({bus.mem_req, bus.busy, bus.f_rvalid, bus.d_rvalid} !== 4'b0000) begin nErr++; $display("FAIL rr_ctrl: got %b want 0000", {bus.mem_req, bus.busy, bus.f_rvalid, bus.d_rvalid}); end
        nCmp++; if (bus.f_rdata !== 32'h0) begin nErr++; $display("FAIL rr_f_rdata: got %h want 0", bus.f_rdata); end
        nCmp++; if (bus.mem_addr !== 64'h0) begin nErr++; $display("FAIL rr_mem_addr: got %h want 0", bus.mem_addr); end
        step();
        reset = 1'b1;
        bus.mem_rvalid = 1'b1; bus.mem_rdata = 64'h77;
        step();
        bus.mem_rvalid = 1'b0;
        nCmp++; if ({bus.f_rvalid, bus.d_rvalid, bus.busy} !== 3'b000) begin nErr++; $display("FAIL rr_late_rvalid: got %b want 000", {bus.f_rvalid, bus.d_rvalid, bus.busy}); end
        step();
    endtask

    task automatic test_starvation();
        bit gk [10];
        int n;
        bit wantF;
        n = 0;
        bus.f_req = 1'b1; bus.f_addr = 64'h6000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_type = 3'b011; bus.d_addr = 64'h7000;
        bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = '0;
        for (int c = 0; c < 60 && n < 10; c++) begin
            #1;
            if (bus.f_gnt && bus.d_gnt) begin
                nCmp++; nErr++;
                $display("FAIL sv_both_gnt: got 11 want at most one");
            end
            if (bus.f_gnt || bus.d_gnt) begin
                gk[n] = bus.f_gnt;
                n++;
            end
            step();
        end
        bus.f_req = 1'b0; bus.d_req = 1'b0;
        for (int c = 0; c < 4; c++) step();
        bus.mem_ready = 1'b0; bus.mem_rvalid = 1'b0;
        step();
        nCmp++; if (n != 10) begin nErr++; $display("FAIL sv_grant_count: got %0d want 10", n); end
        for (int i = 0; i < n; i++) begin
`ifdef MEM_ARB_STARVE_GUARD_EN
            wantF = ((i % 5) == 4);
`else
            wantF = 1'b0;
`endif
            nCmp++; if (gk[i] !== wantF) begin nErr++; $display("FAIL sv_grant%0d: got fetch=%b want fetch=%b", i, gk[i], wantF); end
        end
    endtask

    // Transaction-level reference: one open transaction, grants only when none is open.
    task automatic test_random();
        bit fPend, dPend, dWe, force_, expF, expD, realRv, rdy;
        logic [63:0] fA, dA, dW, rd, sData;
        logic [2:0]  dT;
        bit txnOpen, txnData, txnWe, txnAcc, sF, sD;
        logic [63:0] txnAddr, txnWdata;
        logic [2:0]  txnType;
        int rdLat, losses;
        fPend = 0; dPend = 0; dWe = 0; fA = '0; dA = '0; dW = '0; dT = '0;
        txnOpen = 0; txnData = 0; txnWe = 0; txnAcc = 0; sF = 0; sD = 0; sData = '0;
        txnAddr = '0; txnWdata = '0; txnType = '0; rdLat = 0; losses = 0;
        for (int c = 0; c < 500; c++) begin
            nCmp++; if ({bus.f_rvalid, bus.d_rvalid} !== {sF, sD}) begin nErr++; $display("FAIL rnd_rvalid@%0d: got %b want %b", c, {bus.f_rvalid, bus.d_rvalid}, {sF, sD}); end
            if (sF) begin nCmp++; if (bus.f_rdata !== sData[31:0]) begin nErr++; $display("FAIL rnd_f_rdata@%0d: got %h want %h", c, bus.f_rdata, sData[31:0]); end end
            if (sD) begin nCmp++; if (bus.d_rdata !== sData) begin nErr++; $display("FAIL rnd_d_rdata@%0d: got %h want %h", c, bus.d_rdata, sData); end end
            nCmp++; if (bus.mem_req !== (txnOpen && !txnAcc)) begin nErr++; $display("FAIL rnd_mem_req@%0d: got %b want %b", c, bus.mem_req, txnOpen && !txnAcc); end
            if (txnOpen && !txnAcc) begin
                nCmp++;
                if ({bus.mem_addr, bus.mem_we, bus.mem_type} !== {txnAddr, txnWe, txnType}) begin
                    nErr++;
                    $display("FAIL rnd_fields@%0d: got %h/%b/%b want %h/%b/%b", c, bus.mem_addr, bus.mem_we, bus.mem_type, txnAddr, txnWe, txnType);
                end
                if (txnWe) begin nCmp++; if (bus.mem_wdata !== txnWdata) begin nErr++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, bus.mem_wdata, txnWdata); end end
            end
            nCmp++; if (bus.busy !== txnOpen) begin nErr++; $display("FAIL rnd_busy@%0d: got %b want %b", c, bus.busy, txnOpen); end
            sF = 0; sD = 0;

            if (!fPend && $urandom_range(2) == 0) begin fPend = 1; fA = {$urandom, $urandom}; end
            if (!dPend && $urandom_range(2) == 0) begin
                dPend = 1; dWe = 1'($urandom_range(1)); dT = 3'($urandom);
                dA = {$urandom, $urandom}; dW = {$urandom, $urandom};
            end
            bus.f_req = fPend; bus.f_addr = fA;
            bus.d_req = dPend; bus.d_we = dWe; bus.d_type = dT; bus.d_addr = dA; bus.d_wdata = dW;

            rdy = 1'($urandom_range(1));
            rd  = {$urandom, $urandom};
            realRv = txnOpen && txnAcc && (rdLat == 0);
            bus.mem_ready = rdy;
            bus.mem_rdata = rd;
            if (realRv) bus.mem_rvalid = 1'b1;
            else if (txnOpen && !txnAcc) bus.mem_rvalid = ($urandom_range(3) == 0);
            else bus.mem_rvalid = 1'b0;
            #1;

            force_ = 1'b0;
`ifdef MEM_ARB_STARVE_GUARD_EN
            force_ = fPend && (losses == 4);
`endif
            expF = 0; expD = 0;
            if (!txnOpen) begin
                expF = fPend && (!dPend || force_);
                expD = dPend && !expF;
            end
            nCmp++; if ({bus.f_gnt, bus.d_gnt} !== {expF, expD}) begin nErr++; $display("FAIL rnd_gnt@%0d: got %b want %b", c, {bus.f_gnt, bus.d_gnt}, {expF, expD}); end

            if (txnOpen && !txnAcc) begin
                if (rdy) begin
                    txnAcc = 1;
                    if (txnWe) begin sD = 1; sData = '0; txnOpen = 0; end
                    else rdLat = $urandom_range(2);
                end
            end else if (txnOpen) begin
                if (realRv) begin
                    if (txnData) sD = 1; else sF = 1;
                    sData = rd; txnOpen = 0;
                end else begin
                    rdLat--;
                end
            end
            if (expD || expF) begin
                txnOpen = 1; txnAcc = 0; txnData = expD;
                txnWe    = expD ? dWe : 1'b0;
                txnType  = expD ? dT  : 3'b010;
                txnAddr  = expD ? dA  : fA;
                txnWdata = dW;
                if (expD) begin
                    if (fPend && losses < 4) losses++;
                    dPend = 0;
                end else begin
                    losses = 0;
                    fPend = 0;
                end
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        nCmp = 0;
        nErr = 0;
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_single_fetch();
        test_priority();
        test_spurious_rvalid();
        test_store_wait();
        test_reset_in_resp();
        test_starvation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory bus between the instruction-fetch requester (F) and the data-access requester (M stage) of the pipelined core.
- Sits between the core's fetch/memory-stage ports and the unified memory.
- Handles one outstanding transaction at a time. Data has priority over fetch.
- Each requester gets a grant strobe and a response strobe; the core derives its stall signals from these.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data-bus width
INSTR_W, 32, fetch return width (low INSTR_W bits of mem_rdata)
MTYPE_W, 3, memory access type width
STARVE_MAX, 4, consecutive fetch losses before fetch is forced to win (optional feature only)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
f_req  in  1  fetch request, held until f_gnt
f_addr  in  ADDR_W  fetch address
f_gnt  out  1  fetch request accepted this cycle
f_rvalid  out  1  one-cycle fetch response strobe
f_rdata  out  INSTR_W  fetched instruction
d_req  in  1  data request, held until d_gnt
d_we  in  1  1 = store, 0 = load
d_type  in  MTYPE_W  access size/sign type
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle data completion strobe (loads and stores)
d_rdata  out  DATA_W  load data (0 for stores)
mem_req  out  1  registered request to memory
mem_we  out  1  write enable (0 for fetch)
mem_type  out  MTYPE_W  access type (fetch uses word type, constant 3'b010)
mem_addr  out  ADDR_W  address
mem_wdata  out  DATA_W  write data
mem_ready  in  1  memory accepts request when mem_req and mem_ready are both high
mem_rvalid  in  1  read data valid
mem_rdata  in  DATA_W  read data
busy  out  1  state != IDLE

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE.
  - All outputs 0, all captured registers 0, starvation counter 0.
  - Any in-flight response is discarded; a late mem_rvalid after reset release is ignored because state is IDLE.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - Arbitration is combinational.
  - d_req wins over f_req. f_gnt / d_gnt = IDLE & selected request, asserted in the same cycle.
  - On a grant:
    - capture owner, we, type, addr and wdata;
    - set mem_req = 1 at the next edge;
    - move to REQ.
  - No request: stay in IDLE.
- REQ:
  - mem_req and its fields are held stable until mem_ready.
  - On mem_req & mem_ready: mem_req drops at the next edge.
    - Store: next state IDLE, and d_rvalid pulses the cycle after acceptance with d_rdata = 0.
    - Load/fetch: next state RESP.
  - mem_rvalid in REQ is ignored.
- RESP:
  - Wait for mem_rvalid.
  - On mem_rvalid: register mem_rdata into the owner's rdata; pulse the owner's rvalid for exactly one cycle (next cycle); return to IDLE.
  - rdata holds its value until the next response to that owner.
- Grants occur only in IDLE. Requests raised in REQ/RESP get no grant and must be held.
- Minimum read latency:
  - gnt at cycle 0;
  - mem_req at cycle 1 (mem_ready = 1);
  - mem_rvalid at cycle 2;
  - rvalid at cycle 3.
- A new grant may occur in the same cycle an rvalid pulse is output, since state is IDLE.
- f_rvalid and d_rvalid are never both asserted.
- f_gnt and d_gnt are never both asserted.
- Widths: f_rdata = mem_rdata[INSTR_W-1:0]. No address translation or alignment checking; d_type is passed through unmodified.

Optional Feature:
- Macro: MEM_ARB_STARVE_GUARD_EN.
- When defined, a counter (width clog2(STARVE_MAX+1)) tracks fetch losses:
  - increments, saturating, each time d_gnt is issued while f_req = 1;
  - clears on f_gnt.
  - When counter == STARVE_MAX and f_req = 1, fetch wins over d_req.
- When undefined: strict data priority and no counter logic.

Test Plan:
- Single fetch, f_addr=0x1000, mem_ready=1, mem_rvalid 1 cycle after acceptance with rdata=0x00000013 -> f_gnt at cycle 0, mem_req at cycle 1, f_rvalid=1 with f_rdata=0x00000013 at cycle 3, busy low at cycle 3.
- f_req and d_req (load, addr 0x2000) in the same cycle -> d_gnt=1, f_gnt=0, mem_addr=0x2000. After d_rvalid, f_gnt in the next IDLE cycle and mem_addr=0x1000.
- Store, d_addr=0x3008, d_wdata=0xDEADBEEF, mem_ready held low 3 cycles -> mem_req/addr/wdata stable for those 3 cycles. Accepted on the 4th cycle; d_rvalid one cycle later with d_rdata=0.
- Spurious mem_rvalid=1 while in REQ (mem_ready=0) -> no rvalid strobe. The real response in RESP delivers the correct data.
- reset asserted while in RESP, then mem_rvalid arrives after release -> all outputs 0 immediately, no rvalid, state IDLE.
- With MEM_ARB_STARVE_GUARD_EN and STARVE_MAX=4, d_req and f_req held high continuously -> 4 data grants, then 1 fetch grant, repeating. Without the macro -> fetch never granted.
